vga_csr_regs: RTL and testbench

VGA_CSR_REGS -- requirements
Module: vga_csr_regs

---
 rtl/vga_csr_pkg.sv | 71 +++++++
 rtl/vga_csr_regs.sv | 153 +++++++++++++++
 tb/tb_vga_csr_regs.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_csr_pkg.sv
// VGA CSR block: register map, field positions and timing defaults.
// Shared by the register file and anything that decodes its outputs.
package vga_csr_pkg;

   localparam logic [7:0] ADDR_ID      = 8'h00;
   localparam logic [7:0] ADDR_CTRL    = 8'h04;
   localparam logic [7:0] ADDR_STATUS  = 8'h08;
   localparam logic [7:0] ADDR_FB_BASE = 8'h0C;
   localparam logic [7:0] ADDR_H_TIM   = 8'h10;
   localparam logic [7:0] ADDR_V_TIM   = 8'h14;
   localparam logic [7:0] ADDR_SCRATCH = 8'h18;

   localparam logic [31:0] ID_VALUE = 32'h5647_4131;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_COMMIT_BIT = 2;

   localparam int STAT_VSYNC_BIT  = 0;
   localparam int STAT_COMMIT_BIT = 1;
   localparam int STAT_FCNT_LSB   = 16;
   localparam int FCNT_W          = 16;

   localparam int TIM_W       = 12;
   localparam int TIM_ACT_LSB = 0;
   localparam int TIM_TOT_LSB = 16;

   localparam logic [TIM_W-1:0] H_ACTIVE_RST = 12'd640;
   localparam logic [TIM_W-1:0] H_TOTAL_RST  = 12'd800;
   localparam logic [TIM_W-1:0] V_ACTIVE_RST = 12'd480;
   localparam logic [TIM_W-1:0] V_TOTAL_RST  = 12'd525;

   typedef enum logic [2:0] {
      REG_ID,
      REG_CTRL,
      REG_STATUS,
      REG_FB_BASE,
      REG_H_TIM,
      REG_V_TIM,
      REG_SCRATCH,
      REG_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [7:0] a);
      reg_sel_e s;
      s = REG_NONE;
      unique case (1'b1)
         (a == ADDR_ID):      s = REG_ID;
         (a == ADDR_CTRL):    s = REG_CTRL;
         (a == ADDR_STATUS):  s = REG_STATUS;
         (a == ADDR_FB_BASE): s = REG_FB_BASE;
         (a == ADDR_H_TIM):   s = REG_H_TIM;
         (a == ADDR_V_TIM):   s = REG_V_TIM;
         (a == ADDR_SCRATCH): s = REG_SCRATCH;
         default:             s = REG_NONE;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] pack_timing(
      input logic [TIM_W-1:0] act,
      input logic [TIM_W-1:0] tot
   );
      logic [31:0] w;
      w = '0;
      w[TIM_ACT_LSB +: TIM_W] = act;
      w[TIM_TOT_LSB +: TIM_W] = tot;
      return w;
   endfunction

endpackage

// File: rtl/vga_csr_regs.sv
// VGA control/status registers with frame-synchronous shadow commit.
// Shadowed timing/base registers move to the outputs on frame_start.
module vga_csr_regs
   import vga_csr_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       csr_address,
   input  logic             csr_write,
   input  logic [31:0]      csr_wr_data,
   input  logic             csr_read,
   output logic [31:0]      csr_rd_data,
   input  logic             frame_start,
   output logic             ctrl_enable,
   output logic             irq,
   output logic [31:0]      fb_base,
   output logic [TIM_W-1:0] h_active,
   output logic [TIM_W-1:0] h_total,
   output logic [TIM_W-1:0] v_active,
   output logic [TIM_W-1:0] v_total
);

   reg_sel_e          sel;
   logic [31:0]       rd_next;
   logic              irq_en;
   logic              commit_pending;
   logic              vsync_pend;
   logic [FCNT_W-1:0] frame_count;
   logic [31:0]       scratch;
   logic [31:0]       fb_base_sh;
   logic [TIM_W-1:0]  h_act_sh, h_tot_sh;
   logic [TIM_W-1:0]  v_act_sh, v_tot_sh;
   logic              wr_ctrl, wr_status, wr_fb, wr_h, wr_v, wr_scr;
   logic              commit_fire;

   assign sel         = decode_addr(csr_address);
   assign wr_ctrl     = csr_write && (sel == REG_CTRL);
   assign wr_status   = csr_write && (sel == REG_STATUS);
   assign wr_fb       = csr_write && (sel == REG_FB_BASE);
   assign wr_h        = csr_write && (sel == REG_H_TIM);
   assign wr_v        = csr_write && (sel == REG_V_TIM);
   assign wr_scr      = csr_write && (sel == REG_SCRATCH);
   // Uses the pending flag as it stood before this edge
   assign commit_fire = frame_start && commit_pending;

   always_comb begin
      rd_next = '0;
      unique case (sel)
         REG_ID:      rd_next = ID_VALUE;
         REG_CTRL: begin
            rd_next[CTRL_EN_BIT]     = ctrl_enable;
            rd_next[CTRL_IRQ_EN_BIT] = irq_en;
         end
         REG_STATUS: begin
            rd_next[STAT_VSYNC_BIT]  = vsync_pend;
            rd_next[STAT_COMMIT_BIT] = commit_pending;
            rd_next[STAT_FCNT_LSB +: FCNT_W] = frame_count;
         end
         REG_FB_BASE: rd_next = fb_base_sh;
         REG_H_TIM:   rd_next = pack_timing(h_act_sh, h_tot_sh);
         REG_V_TIM:   rd_next = pack_timing(v_act_sh, v_tot_sh);
         REG_SCRATCH: rd_next = scratch;
         default:     rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csr_rd_data <= '0;
      end else if (csr_read) begin
         csr_rd_data <= rd_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_enable    <= 1'b0;
         irq_en         <= 1'b0;
         commit_pending <= 1'b0;
         scratch        <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_enable <= csr_wr_data[CTRL_EN_BIT];
            irq_en      <= csr_wr_data[CTRL_IRQ_EN_BIT];
         end
         if (commit_fire) begin
            commit_pending <= 1'b0;
         end
         // A new request re-arms for the following frame
         if (wr_ctrl && csr_wr_data[CTRL_COMMIT_BIT]) begin
            commit_pending <= 1'b1;
         end
         if (wr_scr) begin
            scratch <= csr_wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_pend  <= 1'b0;
         frame_count <= '0;
         irq         <= 1'b0;
      end else begin
         if (frame_start) begin
            vsync_pend  <= 1'b1;
            frame_count <= frame_count + 1'b1;
         end else if (wr_status && csr_wr_data[STAT_VSYNC_BIT]) begin
            vsync_pend <= 1'b0;
         end
         irq <= vsync_pend && irq_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_base_sh <= '0;
         h_act_sh   <= H_ACTIVE_RST;
         h_tot_sh   <= H_TOTAL_RST;
         v_act_sh   <= V_ACTIVE_RST;
         v_tot_sh   <= V_TOTAL_RST;
      end else begin
         if (wr_fb) begin
            fb_base_sh <= csr_wr_data;
         end
         if (wr_h) begin
            h_act_sh <= csr_wr_data[TIM_ACT_LSB +: TIM_W];
            h_tot_sh <= csr_wr_data[TIM_TOT_LSB +: TIM_W];
         end
         if (wr_v) begin
            v_act_sh <= csr_wr_data[TIM_ACT_LSB +: TIM_W];
            v_tot_sh <= csr_wr_data[TIM_TOT_LSB +: TIM_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_base  <= '0;
         h_active <= H_ACTIVE_RST;
         h_total  <= H_TOTAL_RST;
         v_active <= V_ACTIVE_RST;
         v_total  <= V_TOTAL_RST;
      end else if (commit_fire) begin
         fb_base  <= fb_base_sh;
         h_active <= h_act_sh;
         h_total  <= h_tot_sh;
         v_active <= v_act_sh;
         v_total  <= v_tot_sh;
      end
   end

endmodule

// File: tb/tb_vga_csr_regs.sv
// Self-checking bench for vga_csr_regs.
// Read expectations queue at issue and are compared when data returns.
module tb_vga_csr_regs;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  csr_address = '0;
   logic        csr_write = 1'b0;
   logic [31:0] csr_wr_data = '0;
   logic        csr_read = 1'b0;
   logic [31:0] csr_rd_data;
   logic        frame_start = 1'b0;
   logic        ctrl_enable;
   logic        irq;
   logic [31:0] fb_base;
   logic [11:0] h_active, h_total, v_active, v_total;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp;

   vga_csr_regs dut (
      .clk         (clk),
      .reset       (reset),
      .csr_address (csr_address),
      .csr_write   (csr_write),
      .csr_wr_data (csr_wr_data),
      .csr_read    (csr_read),
      .csr_rd_data (csr_rd_data),
      .frame_start (frame_start),
      .ctrl_enable (ctrl_enable),
      .irq         (irq),
      .fb_base     (fb_base),
      .h_active    (h_active),
      .h_total     (h_total),
      .v_active    (v_active),
      .v_total     (v_total)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      csr_address = a;
      csr_wr_data = d;
      csr_write   = 1'b1;
      cyc();
      csr_write   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      csr_address = a;
      csr_read    = 1'b1;
      cyc();
      csr_read    = 1'b0;
   endtask

   task automatic pulse(input int n);
      frame_start = 1'b1;
      repeat (n) cyc();
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      @(negedge clk);
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      total++;
      if (csr_rd_data !== 32'h0 || fb_base !== 32'h0) begin
         bad++;
         $display("FAIL reset_zero rd=%h fb=%h exp=0", csr_rd_data, fb_base);
      end
      total++;
      if ({h_active, h_total, v_active, v_total} !==
          {12'd640, 12'd800, 12'd480, 12'd525}) begin
         bad++;
         $display("FAIL reset_timing got=%0d/%0d/%0d/%0d exp=640/800/480/525",
                  h_active, h_total, v_active, v_total);
      end
      total++;
      if (irq !== 1'b0 || ctrl_enable !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl irq=%b en=%b exp=0/0", irq, ctrl_enable);
      end
      @(negedge clk);
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_id_read();
      rd(8'h00, 32'h5647_4131);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL id_read got=%h exp=%h", csr_rd_data, exp);
      end
      rd(8'h10, 32'h0320_0280);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL h_tim_rst got=%h exp=%h", csr_rd_data, exp);
      end
      rd(8'h14, 32'h020D_01E0);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL v_tim_rst got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_shadow_no_commit();
      do_reset();
      wr(8'h10, 32'hF420_7320);
      pulse(3);
      total++;
      if (h_active !== 12'd640 || h_total !== 12'd800) begin
         bad++;
         $display("FAIL no_commit got=%0d/%0d exp=640/800", h_active, h_total);
      end
      rd(8'h10, 32'h0420_0320);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL shadow_rd got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_commit();
      wr(8'h04, 32'h0000_0004);
      rd(8'h08, 32'h0003_0003);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL pend_status got=%h exp=%h", csr_rd_data, exp);
      end
      pulse(1);
      total++;
      if (h_active !== 12'd800 || h_total !== 12'd1056) begin
         bad++;
         $display("FAIL commit got=%0d/%0d exp=800/1056", h_active, h_total);
      end
      rd(8'h08, 32'h0004_0001);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL post_commit_status got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_commit_coincide();
      wr(8'h14, 32'h0200_0190);
      csr_address = 8'h04;
      csr_wr_data = 32'h0000_0006;
      csr_write   = 1'b1;
      frame_start = 1'b1;
      cyc();
      csr_write   = 1'b0;
      frame_start = 1'b0;
      total++;
      if (v_active !== 12'd480 || v_total !== 12'd525) begin
         bad++;
         $display("FAIL coincide_commit got=%0d/%0d exp=480/525", v_active, v_total);
      end
      pulse(1);
      total++;
      if (v_active !== 12'd400 || v_total !== 12'd512) begin
         bad++;
         $display("FAIL next_commit got=%0d/%0d exp=400/512", v_active, v_total);
      end
   endtask

   task automatic test_shadow_race();
      wr(8'h0C, 32'h0000_1000);
      wr(8'h04, 32'h0000_0004);
      csr_address = 8'h0C;
      csr_wr_data = 32'h0000_2000;
      csr_write   = 1'b1;
      frame_start = 1'b1;
      cyc();
      csr_write   = 1'b0;
      frame_start = 1'b0;
      total++;
      if (fb_base !== 32'h0000_1000) begin
         bad++;
         $display("FAIL race_active got=%h exp=%h", fb_base, 32'h1000);
      end
      rd(8'h0C, 32'h0000_2000);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL race_shadow got=%h exp=%h", csr_rd_data, exp);
      end
      pulse(1);
      total++;
      if (fb_base !== 32'h0000_1000) begin
         bad++;
         $display("FAIL no_recommit got=%h exp=%h", fb_base, 32'h1000);
      end
   endtask

   task automatic test_irq();
      do_reset();
      wr(8'h04, 32'h0000_0002);
      pulse(1);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_lag got=%b exp=0", irq);
      end
      cyc();
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_set got=%b exp=1", irq);
      end
      wr(8'h08, 32'h0000_0001);
      cyc();
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_w1c got=%b exp=0", irq);
      end
      pulse(1);
      csr_address = 8'h08;
      csr_wr_data = 32'h0000_0001;
      csr_write   = 1'b1;
      frame_start = 1'b1;
      cyc();
      csr_write   = 1'b0;
      frame_start = 1'b0;
      cyc();
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_set_wins got=%b exp=1", irq);
      end
      wr(8'h04, 32'h0000_0003);
      total++;
      if (ctrl_enable !== 1'b1) begin
         bad++;
         $display("FAIL ctrl_enable got=%b exp=1", ctrl_enable);
      end
      rd(8'h04, 32'h0000_0003);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL ctrl_rd got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_rw_same();
      wr(8'h18, 32'h0000_A5A5);
      exp_q.push_back(32'h0000_A5A5);
      csr_address = 8'h18;
      csr_wr_data = 32'h0000_5A5A;
      csr_write   = 1'b1;
      csr_read    = 1'b1;
      cyc();
      csr_write   = 1'b0;
      csr_read    = 1'b0;
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL rw_same got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(32'h5647_4131);
      exp_q.push_back(32'h0000_5A5A);
      csr_read    = 1'b1;
      csr_address = 8'h00;
      cyc();
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL b2b_first got=%h exp=%h", csr_rd_data, exp);
      end
      csr_address = 8'h18;
      cyc();
      csr_read = 1'b0;
      csr_address = 8'h00;
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL b2b_second got=%h exp=%h", csr_rd_data, exp);
      end
      cyc();
      cyc();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL rd_hold got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_unmapped();
      wr(8'h1C, 32'hFFFF_FFFF);
      wr(8'h19, 32'hFFFF_FFFF);
      rd(8'h1C, 32'h0);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL unmapped_1c got=%h exp=%h", csr_rd_data, exp);
      end
      rd(8'h0D, 32'h0);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL unaligned_0d got=%h exp=%h", csr_rd_data, exp);
      end
      rd(8'h18, 32'h0000_5A5A);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL unaligned_wr got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_frame_wrap();
      do_reset();
      pulse(65535);
      rd(8'h08, 32'hFFFF_0001);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL fcnt_max got=%h exp=%h", csr_rd_data, exp);
      end
      pulse(1);
      rd(8'h08, 32'h0000_0001);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL fcnt_wrap got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   task automatic test_reset_mid();
      wr(8'h0C, 32'h0000_1234);
      wr(8'h04, 32'h0000_0004);
      csr_address = 8'h04;
      csr_wr_data = 32'h0000_0007;
      csr_write   = 1'b1;
      #2;
      reset = 1'b1;
      #2;
      csr_write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cyc();
      total++;
      if (ctrl_enable !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_en got=%b exp=0", ctrl_enable);
      end
      rd(8'h08, 32'h0);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL mid_reset_status got=%h exp=%h", csr_rd_data, exp);
      end
      rd(8'h0C, 32'h0);
      exp = exp_q.pop_front();
      total++;
      if (csr_rd_data !== exp) begin
         bad++;
         $display("FAIL mid_reset_fb got=%h exp=%h", csr_rd_data, exp);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_id_read();
      test_shadow_no_commit();
      test_commit();
      test_commit_coincide();
      test_shadow_race();
      test_irq();
      test_rw_same();
      test_back_to_back();
      test_unmapped();
      test_frame_wrap();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
